peg_l2_mac_rx_filter: RTL
=========================

PEG_L2_MAC_RX_FILTER -- requirements
Module: peg_l2_mac_rx_filter

Interface
REQ-001 SHALL have parameters: NUM_FIELDS, default 8, width of the field-valid vector; BFFR_SIZE, default 48, width of the header buffer; FCS_TMOUT, default 16, cycles allowed for the FCS result.
REQ-002 SHALL use field indices DADDR=0, SADDR=1, LEN_TYPE=2, VLAN_TAG=3, CTRL_OPCODE=4, PAUSE_TIME=5, FCS=6.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst_n  in  1  synchronous, active-low reset.
REQ-005 config_l2_mac_rx_filter_en, _promisc_en, _bcast_en, _mcast_en, _pause_en, _fcs_en  in  1 each  filter, promiscuous, broadcast, multicast, pause-consume and FCS-check enables.
REQ-006 config_l2_mac_rx_station_addr  in  48  station MAC address, first wire byte in [47:40].
REQ-007 config_l2_mac_rx_stats_clr  in  1  synchronous clear of both statistics counters.
REQ-008 rx_field_valid_vec  in  NUM_FIELDS  one-cycle field strobes from the RX parser.
REQ-009 rx_bffr  in  BFFR_SIZE  parser shift buffer; newest byte in [7:0].
REQ-010 rx_fcs_result_valid, rx_fcs_result_ok  in  1 each  FCS check pulse and pass flag.
REQ-011 rx_frm_dcsn_valid  out  1  one-cycle per-frame decision strobe.
REQ-012 rx_frm_accept  out  1  1=forward frame, 0=drop; qualified by rx_frm_dcsn_valid.
REQ-013 rx_frm_drop_reason  out  3  0 none, 1 DA mismatch, 2 FCS error, 3 FCS timeout, 4 pause consumed, 5 unsupported control, 6 aborted.
REQ-014 rx_pause_valid  out  1  pause request strobe to the pause generator; rx_pause_time  out  16  pause quanta.
REQ-015 rx_frm_cntr, rx_drop_cntr  out  16 each  accepted and dropped frame counts.
REQ-016 l2_mac_rx_filter_fsm_state  out  2  current FSM state.

Function
REQ-017 FSM states SHALL be IDLE_S=0, HDR_S=1, WAIT_FCS_S=2.
REQ-018 IDLE_S -> HDR_S on DADDR strobe; DA=rx_bffr[47:0] and all config inputs SHALL be latched on that cycle and held for the frame.
REQ-019 In HDR_S, CTRL_OPCODE strobe SHALL latch ctrl flag; pause flag set if rx_bffr[15:0]==16'h0001; PAUSE_TIME strobe SHALL latch rx_bffr[15:0] into pause time.
REQ-020 In HDR_S, FCS strobe: FCS check enabled -> WAIT_FCS_S with timeout counter cleared; else decision issued next cycle, -> IDLE_S.
REQ-021 In WAIT_FCS_S, rx_fcs_result_valid SHALL yield decision next cycle, -> IDLE_S; after FCS_TMOUT cycles without it, decision with reason 3, -> IDLE_S.
REQ-022 DA match = promisc | DA==station | (bcast_en & DA==48'hFFFFFFFFFFFF) | (mcast_en & DA[40] & DA!=all-ones); filter_en=0 forces match.
REQ-023 Reason priority SHALL be FCS error > FCS timeout > DA mismatch > pause consumed > unsupported control; first true reason reported; none -> accept=1, reason=0.
REQ-024 Pause consumed when pause flag & pause_en; rx_pause_valid SHALL pulse with the decision only if FCS ok (or check disabled) and DA==station or 48'h0180C2000001.
REQ-025 Non-pause control frame (ctrl flag, opcode!=1) SHALL be dropped reason 5.
REQ-026 DADDR strobe in HDR_S or WAIT_FCS_S SHALL abort the current frame: decision next cycle with reason 6, new frame capture starts -> HDR_S.
REQ-027 rx_fcs_result_valid in IDLE_S or HDR_S SHALL be ignored.
REQ-028 rx_frm_cntr increments on accept decisions, rx_drop_cntr on drop decisions; both saturate at 16'hFFFF; stats_clr wins over same-cycle increment.
REQ-029 rx_frm_dcsn_valid and rx_pause_valid SHALL never assert on consecutive cycles for one frame.

Reset
REQ-030 rst_n low at a clock edge SHALL force IDLE_S, all strobes 0, rx_frm_accept 0, reason 0, rx_pause_time 0, both counters 0, mid-frame state discarded without a decision.

Verification
REQ-031 Unicast DA=station, fcs_en=1, result ok 3 cycles after FCS strobe -> dcsn_valid 1 cycle later, accept=1, reason=0, rx_frm_cntr=1.
REQ-032 DA=00-11-22-33-44-55 != station, promisc=0, filter_en=1, fcs_en=0 -> accept=0, reason=1, rx_drop_cntr=1.
REQ-033 Pause frame DA=01-80-C2-00-00-01, opcode 0x0001, time 0x00FF, FCS ok, pause_en=1 -> rx_pause_valid with time 0x00FF, accept=0, reason=4.
REQ-034 fcs_en=1, no FCS result for 16 cycles -> reason=3; result ok arriving later ignored, FSM IDLE_S.
REQ-035 Second DADDR strobe in WAIT_FCS_S -> reason=6 decision, FSM HDR_S; counters at 16'hFFFF stay saturated; stats_clr with decision -> counters 0.

Source files
------------

// File: rtl/peg_l2_mac_rx_filter.sv
// ----------------------------------------------------------------------------
// peg_l2_mac_rx_filter
//
// Per-frame receive filter for the L2 MAC. It tracks the parser's field
// strobes, captures the destination address and a snapshot of the filter
// configuration when a frame starts, optionally waits for the FCS checker,
// and then issues one accept/drop decision per frame. Pause frames addressed
// to this station (or to the reserved pause group address) are turned into a
// pause request for the local pause generator.
//
// Ports
//   clk, rst_n                       clock, synchronous active-low reset
//   config_l2_mac_rx_filter_*_en     filter / promiscuous / broadcast /
//                                    multicast / pause-consume / FCS enables
//   config_l2_mac_rx_station_addr    station MAC, first wire byte in [47:40]
//   config_l2_mac_rx_stats_clr       clears both statistics counters
//   rx_field_valid_vec               one-cycle field strobes from the parser
//   rx_bffr                          parser shift buffer, newest byte [7:0]
//   rx_fcs_result_valid/_ok          FCS check pulse and pass flag
//   rx_frm_dcsn_valid                one-cycle decision strobe
//   rx_frm_accept                    1 = forward, 0 = drop
//   rx_frm_drop_reason               0 none, 1 DA, 2 FCS err, 3 FCS timeout,
//                                    4 pause consumed, 5 unsupported ctrl,
//                                    6 aborted
//   rx_pause_valid, rx_pause_time    pause request strobe and quanta
//   rx_frm_cntr, rx_drop_cntr        saturating accept / drop counters
//   l2_mac_rx_filter_fsm_state       current FSM state
// ----------------------------------------------------------------------------
module peg_l2_mac_rx_filter #(
    parameter int NUM_FIELDS = 8,
    parameter int BFFR_SIZE  = 48,
    parameter int FCS_TMOUT  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  config_l2_mac_rx_filter_en,
    input  logic                  config_l2_mac_rx_filter_promisc_en,
    input  logic                  config_l2_mac_rx_filter_bcast_en,
    input  logic                  config_l2_mac_rx_filter_mcast_en,
    input  logic                  config_l2_mac_rx_filter_pause_en,
    input  logic                  config_l2_mac_rx_filter_fcs_en,
    input  logic [47:0]           config_l2_mac_rx_station_addr,
    input  logic                  config_l2_mac_rx_stats_clr,
    input  logic [NUM_FIELDS-1:0] rx_field_valid_vec,
    input  logic [BFFR_SIZE-1:0]  rx_bffr,
    input  logic                  rx_fcs_result_valid,
    input  logic                  rx_fcs_result_ok,
    output logic                  rx_frm_dcsn_valid,
    output logic                  rx_frm_accept,
    output logic [2:0]            rx_frm_drop_reason,
    output logic                  rx_pause_valid,
    output logic [15:0]           rx_pause_time,
    output logic [15:0]           rx_frm_cntr,
    output logic [15:0]           rx_drop_cntr,
    output logic [1:0]            l2_mac_rx_filter_fsm_state
);

    localparam int DADDR       = 0;
    localparam int CTRL_OPCODE = 4;
    localparam int PAUSE_TIME  = 5;
    localparam int FCS         = 6;

    localparam int CNT_W = $clog2(FCS_TMOUT + 1);

    localparam logic [47:0] BCAST_DA = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] PAUSE_DA = 48'h0180_C200_0001;

    localparam logic [2:0] RSN_NONE   = 3'd0;
    localparam logic [2:0] RSN_DA     = 3'd1;
    localparam logic [2:0] RSN_FCS    = 3'd2;
    localparam logic [2:0] RSN_TMOUT  = 3'd3;
    localparam logic [2:0] RSN_PAUSE  = 3'd4;
    localparam logic [2:0] RSN_CTRL   = 3'd5;
    localparam logic [2:0] RSN_ABORT  = 3'd6;

    typedef enum logic [1:0] {
        IDLE_S     = 2'd0,
        HDR_S      = 2'd1,
        WAIT_FCS_S = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   tmout_cnt_reg, tmout_cnt_next;

    // Per-frame context, frozen at the DADDR strobe
    logic [47:0] da_reg, station_reg;
    logic        filter_en_reg, promisc_en_reg, bcast_en_reg, mcast_en_reg;
    logic        pause_en_reg, fcs_en_reg;
    logic        ctrl_flag_reg, pause_flag_reg;
    logic [15:0] pause_time_reg;

    logic strb_daddr, strb_ctrl, strb_ptime, strb_fcs;
    logic capture, dcsn_next, abort_evt, tmout_evt, fcs_err_evt, fcs_good_evt;
    logic da_match, accept_next, pause_next;
    logic [2:0] reason_next;
    logic unused_inputs;

    assign strb_daddr = rx_field_valid_vec[DADDR];
    assign strb_ctrl  = rx_field_valid_vec[CTRL_OPCODE];
    assign strb_ptime = rx_field_valid_vec[PAUSE_TIME];
    assign strb_fcs   = rx_field_valid_vec[FCS];

    // Strobes for fields this block does not act on, and any buffer bits
    // beyond the 48 it inspects.
    assign unused_inputs = ^{rx_field_valid_vec, rx_bffr};

    assign l2_mac_rx_filter_fsm_state = state_reg;

    // ------------------------------------------------------------------
    // Next-state and decision-event logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        tmout_cnt_next = tmout_cnt_reg;
        capture        = 1'b0;
        dcsn_next      = 1'b0;
        abort_evt      = 1'b0;
        tmout_evt      = 1'b0;
        fcs_err_evt    = 1'b0;
        fcs_good_evt   = 1'b0;
        case (state_reg)
            IDLE_S: begin
                if (strb_daddr) begin
                    capture    = 1'b1;
                    state_next = HDR_S;
                end
            end
            HDR_S: begin
                // A new DA while a frame is open means the old one was cut
                // short: close it as aborted and start on the new one.
                if (strb_daddr) begin
                    capture   = 1'b1;
                    dcsn_next = 1'b1;
                    abort_evt = 1'b1;
                end else if (strb_fcs) begin
                    if (fcs_en_reg) begin
                        state_next     = WAIT_FCS_S;
                        tmout_cnt_next = '0;
                    end else begin
                        dcsn_next    = 1'b1;
                        fcs_good_evt = 1'b1;
                        state_next   = IDLE_S;
                    end
                end
            end
            WAIT_FCS_S: begin
                if (strb_daddr) begin
                    capture    = 1'b1;
                    dcsn_next  = 1'b1;
                    abort_evt  = 1'b1;
                    state_next = HDR_S;
                end else if (rx_fcs_result_valid) begin
                    dcsn_next    = 1'b1;
                    fcs_err_evt  = ~rx_fcs_result_ok;
                    fcs_good_evt = rx_fcs_result_ok;
                    state_next   = IDLE_S;
                end else if (tmout_cnt_reg == CNT_W'(FCS_TMOUT - 1)) begin
                    dcsn_next  = 1'b1;
                    tmout_evt  = 1'b1;
                    state_next = IDLE_S;
                end else begin
                    tmout_cnt_next = tmout_cnt_reg + CNT_W'(1);
                end
            end
            default: state_next = IDLE_S;
        endcase
    end

    // ------------------------------------------------------------------
    // Decision content, evaluated on the frame's latched context
    // ------------------------------------------------------------------
    always_comb begin
        da_match = ~filter_en_reg | promisc_en_reg | (da_reg == station_reg) |
                   (bcast_en_reg & (da_reg == BCAST_DA)) |
                   (mcast_en_reg & da_reg[40] & (da_reg != BCAST_DA));

        if (abort_evt)                         reason_next = RSN_ABORT;
        else if (fcs_err_evt)                  reason_next = RSN_FCS;
        else if (tmout_evt)                    reason_next = RSN_TMOUT;
        else if (!da_match)                    reason_next = RSN_DA;
        else if (pause_flag_reg & pause_en_reg) reason_next = RSN_PAUSE;
        else if (ctrl_flag_reg & ~pause_flag_reg) reason_next = RSN_CTRL;
        else                                   reason_next = RSN_NONE;

        accept_next = (reason_next == RSN_NONE);

        pause_next = dcsn_next & fcs_good_evt & pause_flag_reg & pause_en_reg &
                     ((da_reg == station_reg) | (da_reg == PAUSE_DA));
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE_S;
            tmout_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            tmout_cnt_reg <= tmout_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Frame context capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            da_reg         <= '0;
            station_reg    <= '0;
            filter_en_reg  <= 1'b0;
            promisc_en_reg <= 1'b0;
            bcast_en_reg   <= 1'b0;
            mcast_en_reg   <= 1'b0;
            pause_en_reg   <= 1'b0;
            fcs_en_reg     <= 1'b0;
            ctrl_flag_reg  <= 1'b0;
            pause_flag_reg <= 1'b0;
            pause_time_reg <= '0;
        end else if (capture) begin
            da_reg         <= rx_bffr[47:0];
            station_reg    <= config_l2_mac_rx_station_addr;
            filter_en_reg  <= config_l2_mac_rx_filter_en;
            promisc_en_reg <= config_l2_mac_rx_filter_promisc_en;
            bcast_en_reg   <= config_l2_mac_rx_filter_bcast_en;
            mcast_en_reg   <= config_l2_mac_rx_filter_mcast_en;
            pause_en_reg   <= config_l2_mac_rx_filter_pause_en;
            fcs_en_reg     <= config_l2_mac_rx_filter_fcs_en;
            ctrl_flag_reg  <= 1'b0;
            pause_flag_reg <= 1'b0;
            pause_time_reg <= '0;
        end else if (state_reg == HDR_S) begin
            if (strb_ctrl) begin
                ctrl_flag_reg  <= 1'b1;
                pause_flag_reg <= (rx_bffr[15:0] == 16'h0001);
            end
            if (strb_ptime) begin
                pause_time_reg <= rx_bffr[15:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered decision outputs and statistics
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_frm_dcsn_valid  <= 1'b0;
            rx_frm_accept      <= 1'b0;
            rx_frm_drop_reason <= RSN_NONE;
            rx_pause_valid     <= 1'b0;
            rx_pause_time      <= '0;
        end else begin
            rx_frm_dcsn_valid <= dcsn_next;
            rx_pause_valid    <= pause_next;
            if (dcsn_next) begin
                rx_frm_accept      <= accept_next;
                rx_frm_drop_reason <= reason_next;
            end
            if (pause_next) begin
                rx_pause_time <= pause_time_reg;
            end
        end
    end

    // Counters advance with the decision, so they already include the frame
    // while rx_frm_dcsn_valid is high; a clear in the same cycle wins.
    always_ff @(posedge clk) begin
        if (!rst_n || config_l2_mac_rx_stats_clr) begin
            rx_frm_cntr  <= '0;
            rx_drop_cntr <= '0;
        end else if (dcsn_next) begin
            if (accept_next && rx_frm_cntr != 16'hFFFF) begin
                rx_frm_cntr <= rx_frm_cntr + 16'd1;
            end
            if (!accept_next && rx_drop_cntr != 16'hFFFF) begin
                rx_drop_cntr <= rx_drop_cntr + 16'd1;
            end
        end
    end

endmodule
